// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and sizes for the write-back stage
package wb_pkg;

  localparam int WB_DEPTH  = 2;
  localparam int WB_DATA_W = 32;
  localparam int WB_ADDR_W = 4;

  typedef struct packed {
    logic                 wb_en;
    logic [WB_ADDR_W-1:0] dest;
    logic [WB_DATA_W-1:0] value;
  } wb_entry_t;

  typedef enum logic [1:0] {
    WB_EMPTY = 2'd0,
    WB_ONE   = 2'd1,
    WB_FULL  = 2'd2
  } wb_state_e;

endpackage

// File: rtl/wb_skid_buf.sv
// rtl/wb_skid_buf.sv - two-entry result buffer with occupancy FSM and forwarding search
module wb_skid_buf
  import wb_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  wb_entry_t            push_entry,
  input  logic                 pop,
  input  logic [WB_ADDR_W-1:0] fwd_src,
  output wb_state_e            state,
  output wb_entry_t            head_entry,
  output logic                 fwd_hit,
  output logic [WB_DATA_W-1:0] fwd_value
);

  wb_state_e state_q, state_d;
  logic      head_q, head_d;
  logic      tail;
  logic      newer;
  wb_entry_t mem_q [DEPTH];

  // With at most two entries the tail is the head when empty, else the other slot.
  assign newer = ~head_q;
  assign tail  = (state_q == WB_EMPTY) ? head_q : newer;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    if (pop && state_q != WB_EMPTY) head_d = newer;
    case (state_q)
      WB_EMPTY: if (push) state_d = WB_ONE;
      WB_ONE: begin
        if (push && !pop)      state_d = WB_FULL;
        else if (!push && pop) state_d = WB_EMPTY;
      end
      WB_FULL: if (pop) state_d = WB_ONE;
      default: state_d = WB_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WB_EMPTY;
      head_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      if (push) mem_q[tail] <= push_entry;
    end
  end

  assign state      = state_q;
  assign head_entry = mem_q[head_q];

  // Newest pending write wins; the head still hits while it drains.
  always_comb begin
    fwd_hit   = 1'b0;
    fwd_value = '0;
    if (state_q == WB_FULL && mem_q[newer].wb_en && mem_q[newer].dest == fwd_src) begin
      fwd_hit   = 1'b1;
      fwd_value = mem_q[newer].value;
    end else if (state_q != WB_EMPTY && mem_q[head_q].wb_en && mem_q[head_q].dest == fwd_src) begin
      fwd_hit   = 1'b1;
      fwd_value = mem_q[head_q].value;
    end
  end

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - write-back stage; WB_PERF_CNT_EN adds retire/stall counters
module wb_stage
  import wb_pkg::*;
#(
  parameter int BIT_NUMBER = WB_DATA_W,
  parameter int REG_ADDR_W = WB_ADDR_W,
  parameter int DEPTH      = WB_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  freeze,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  wb_en_in,
  input  logic                  mem_r_en_in,
  input  logic [BIT_NUMBER-1:0] alu_result_in,
  input  logic [BIT_NUMBER-1:0] mem_data_in,
  input  logic [REG_ADDR_W-1:0] dest_in,
  input  logic                  rf_busy,
  output logic                  wb_en,
  output logic [REG_ADDR_W-1:0] wb_dest,
  output logic [BIT_NUMBER-1:0] wb_value,
  input  logic [REG_ADDR_W-1:0] fwd_src,
  output logic                  fwd_hit,
  output logic [BIT_NUMBER-1:0] fwd_value,
  output logic                  retired,
  output logic [31:0]           perf_retired,
  output logic [31:0]           perf_rf_stall
);

  wb_state_e state;
  wb_entry_t head;
  wb_entry_t in_entry;
  logic      accept;
  logic      drain;
  logic      occupied;

  assign in_entry.wb_en = wb_en_in;
  assign in_entry.dest  = dest_in;
  assign in_entry.value = mem_r_en_in ? mem_data_in : alu_result_in;

  assign occupied = (state != WB_EMPTY);
  assign in_ready = !freeze && (state != WB_FULL);
  assign accept   = in_valid && in_ready;
  // Non-writing entries never need the register-file port, so rf_busy cannot hold them.
  assign drain    = !rst && occupied && !freeze && (!head.wb_en || !rf_busy);

  assign wb_en    = drain && head.wb_en;
  assign retired  = drain;
  assign wb_dest  = occupied ? head.dest  : '0;
  assign wb_value = occupied ? head.value : '0;

  wb_skid_buf #(
    .DEPTH(DEPTH)
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .push       (accept),
    .push_entry (in_entry),
    .pop        (drain),
    .fwd_src    (fwd_src),
    .state      (state),
    .head_entry (head),
    .fwd_hit    (fwd_hit),
    .fwd_value  (fwd_value)
  );

`ifdef WB_PERF_CNT_EN
  logic [31:0] retired_cnt;
  logic [31:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      retired_cnt <= '0;
      stall_cnt   <= '0;
    end else begin
      if (drain) retired_cnt <= retired_cnt + 32'd1;
      if (occupied && !freeze && head.wb_en && rf_busy) stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign perf_retired  = retired_cnt;
  assign perf_rf_stall = stall_cnt;
`else
  assign perf_retired  = '0;
  assign perf_rf_stall = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - directed self-checking bench for wb_stage
module tb_wb_stage;

`ifdef WB_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        in_valid;
  logic        in_ready;
  logic        wb_en_in;
  logic        mem_r_en_in;
  logic [31:0] alu_result_in;
  logic [31:0] mem_data_in;
  logic [3:0]  dest_in;
  logic        rf_busy;
  logic        wb_en;
  logic [3:0]  wb_dest;
  logic [31:0] wb_value;
  logic [3:0]  fwd_src;
  logic        fwd_hit;
  logic [31:0] fwd_value;
  logic        retired;
  logic [31:0] perf_retired;
  logic [31:0] perf_rf_stall;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk           (clk),
    .rst           (rst),
    .freeze        (freeze),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .wb_en_in      (wb_en_in),
    .mem_r_en_in   (mem_r_en_in),
    .alu_result_in (alu_result_in),
    .mem_data_in   (mem_data_in),
    .dest_in       (dest_in),
    .rf_busy       (rf_busy),
    .wb_en         (wb_en),
    .wb_dest       (wb_dest),
    .wb_value      (wb_value),
    .fwd_src       (fwd_src),
    .fwd_hit       (fwd_hit),
    .fwd_value     (fwd_value),
    .retired       (retired),
    .perf_retired  (perf_retired),
    .perf_rf_stall (perf_rf_stall)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic we, input logic mr, input logic [31:0] alu,
                       input logic [31:0] md, input logic [3:0] d);
    in_valid      = 1'b1;
    wb_en_in      = we;
    mem_r_en_in   = mr;
    alu_result_in = alu;
    mem_data_in   = md;
    dest_in       = d;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic expect_wb(input string tag, input logic en, input logic [3:0] d,
                           input logic [31:0] v);
    chk({tag, "_en"}, {31'd0, wb_en}, {31'd0, en});
    chk({tag, "_dest"}, {28'd0, wb_dest}, {28'd0, d});
    chk({tag, "_value"}, wb_value, v);
  endtask

  initial begin
    rst = 1'b1; freeze = 1'b0; rf_busy = 1'b0; fwd_src = 4'd0;
    in_valid = 1'b0; wb_en_in = 1'b0; mem_r_en_in = 1'b0;
    alu_result_in = '0; mem_data_in = '0; dest_in = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    expect_wb("rst", 1'b0, 4'd0, 32'd0);
    chk("rst_retired", {31'd0, retired}, 32'd0);
    chk("rst_fwd_hit", {31'd0, fwd_hit}, 32'd0);
    chk("rst_perf_ret", perf_retired, 32'd0);
    chk("rst_perf_stall", perf_rf_stall, 32'd0);

    // Three back-to-back ALU results, each written one cycle after capture.
    step(); offer(1, 0, 32'h10, 32'h0, 4'd1); @(negedge clk);
    chk("b2b_rdy0", {31'd0, in_ready}, 32'd1);
    chk("b2b_idle_en", {31'd0, wb_en}, 32'd0);
    step(); offer(1, 0, 32'h20, 32'h0, 4'd2); @(negedge clk);
    expect_wb("b2b_w1", 1'b1, 4'd1, 32'h10);
    chk("b2b_rdy1", {31'd0, in_ready}, 32'd1);
    step(); offer(1, 0, 32'h30, 32'h0, 4'd3); @(negedge clk);
    expect_wb("b2b_w2", 1'b1, 4'd2, 32'h20);
    chk("b2b_rdy2", {31'd0, in_ready}, 32'd1);
    step(); idle(); @(negedge clk);
    expect_wb("b2b_w3", 1'b1, 4'd3, 32'h30);
    step(); @(negedge clk);
    expect_wb("b2b_empty", 1'b0, 4'd0, 32'h0);
    chk("b2b_ret0", {31'd0, retired}, 32'd0);

    // Load selects mem_data.
    step(); offer(1, 1, 32'h100, 32'hDEADBEEF, 4'd5); @(negedge clk);
    step(); idle(); @(negedge clk);
    expect_wb("load", 1'b1, 4'd5, 32'hDEADBEEF);

    // rf_busy for four occupied cycles fills the buffer.
    step(); offer(1, 0, 32'h1, 32'h0, 4'd7); @(negedge clk);
    chk("bsy_rdy0", {31'd0, in_ready}, 32'd1);
    step(); offer(1, 0, 32'h2, 32'h0, 4'd7); rf_busy = 1'b1; @(negedge clk);
    chk("bsy_en1", {31'd0, wb_en}, 32'd0);
    chk("bsy_rdy1", {31'd0, in_ready}, 32'd1);
    step(); offer(1, 0, 32'h90, 32'h0, 4'd9); @(negedge clk);
    chk("bsy_full_rdy", {31'd0, in_ready}, 32'd0);
    chk("bsy_en2", {31'd0, wb_en}, 32'd0);
    fwd_src = 4'd7; #1;
    chk("fwd7_hit", {31'd0, fwd_hit}, 32'd1);
    chk("fwd7_value", fwd_value, 32'h2);
    fwd_src = 4'd8; #1;
    chk("fwd8_hit", {31'd0, fwd_hit}, 32'd0);
    chk("fwd8_value", fwd_value, 32'h0);
    step(); @(negedge clk);
    chk("bsy_rdy3", {31'd0, in_ready}, 32'd0);
    step(); @(negedge clk);
    step(); rf_busy = 1'b0; fwd_src = 4'd7; @(negedge clk);
    expect_wb("bsy_w7a", 1'b1, 4'd7, 32'h1);
    chk("bsy_rdy5", {31'd0, in_ready}, 32'd0);
    chk("bsy_stall", perf_rf_stall, PERF ? 32'd4 : 32'd0);
    chk("drain_fwd_value", fwd_value, 32'h2);
    step(); @(negedge clk);
    expect_wb("bsy_w7b", 1'b1, 4'd7, 32'h2);
    chk("bsy_rdy6", {31'd0, in_ready}, 32'd1);
    step(); idle(); @(negedge clk);
    expect_wb("bsy_w9", 1'b1, 4'd9, 32'h90);
    step(); @(negedge clk);
    expect_wb("bsy_empty", 1'b0, 4'd0, 32'h0);

    // A store-like entry drains past rf_busy without writing.
    step(); offer(0, 0, 32'h44, 32'h0, 4'd4); @(negedge clk);
    step(); idle(); rf_busy = 1'b1; fwd_src = 4'd4; @(negedge clk);
    chk("nowr_retired", {31'd0, retired}, 32'd1);
    expect_wb("nowr", 1'b0, 4'd4, 32'h44);
    chk("nowr_fwd_hit", {31'd0, fwd_hit}, 32'd0);
    step(); rf_busy = 1'b0; @(negedge clk);
    chk("nowr_ret_after", {31'd0, retired}, 32'd0);

    // Freeze holds the buffered entry.
    step(); offer(1, 0, 32'h66, 32'h0, 4'd6); @(negedge clk);
    step(); idle(); freeze = 1'b1; @(negedge clk);
    chk("frz_rdy", {31'd0, in_ready}, 32'd0);
    expect_wb("frz", 1'b0, 4'd6, 32'h66);
    chk("frz_retired", {31'd0, retired}, 32'd0);
    step(); freeze = 1'b0; @(negedge clk);
    expect_wb("frz_rel", 1'b1, 4'd6, 32'h66);
    step(); @(negedge clk);
    chk("perf_ret_total", perf_retired, PERF ? 32'd9 : 32'd0);
    chk("perf_stall_total", perf_rf_stall, PERF ? 32'd4 : 32'd0);

    // Reset of a full buffer discards it without writes.
    step(); rf_busy = 1'b1; offer(1, 0, 32'h11, 32'h0, 4'd1); @(negedge clk);
    step(); offer(1, 0, 32'h22, 32'h0, 4'd2); @(negedge clk);
    step(); offer(1, 0, 32'h33, 32'h0, 4'd3); rf_busy = 1'b0; rst = 1'b1; @(negedge clk);
    chk("rstfull_en", {31'd0, wb_en}, 32'd0);
    step(); rst = 1'b0; idle(); fwd_src = 4'd2; @(negedge clk);
    chk("rstfull_rdy", {31'd0, in_ready}, 32'd1);
    expect_wb("rstfull", 1'b0, 4'd0, 32'h0);
    chk("rstfull_retired", {31'd0, retired}, 32'd0);
    chk("rstfull_fwd", {31'd0, fwd_hit}, 32'd0);
    chk("rstfull_perf_ret", perf_retired, 32'd0);
    chk("rstfull_perf_stall", perf_rf_stall, 32'd0);
    step(); @(negedge clk);
    chk("rstfull_no_wr", {31'd0, wb_en}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Write-back stage directly downstream of the MEM stage in the 5-stage ARM pipeline.
- Captures each MEM result (wb_en, mem_r_en, alu_result, mem_data, dest) into a 2-entry buffer and selects the write-back value at capture.
- Drives the register-file write port, which can be stolen by rf_busy (debug/exception writes).
- Back-pressures MEM via in_ready and offers a forwarding lookup over buffered, not-yet-written results.

Parameters:
BIT_NUMBER, 32, datapath width
REG_ADDR_W, 4, register index width
DEPTH, 2, buffer entries (fixed at 2; other values unsupported)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
freeze  in  1  global pipeline freeze
in_valid  in  1  MEM presents a result this cycle
in_ready  out  1  stage can accept this cycle
wb_en_in  in  1  result writes the register file
mem_r_en_in  in  1  select mem_data_in, not alu_result_in
alu_result_in  in  BIT_NUMBER  ALU result from MEM
mem_data_in  in  BIT_NUMBER  load data from MEM
dest_in  in  REG_ADDR_W  destination register
rf_busy  in  1  register-file write port unavailable
wb_en  out  1  register-file write strobe
wb_dest  out  REG_ADDR_W  write address
wb_value  out  BIT_NUMBER  write data
fwd_src  in  REG_ADDR_W  register to look up
fwd_hit  out  1  buffered pending write to fwd_src exists
fwd_value  out  BIT_NUMBER  value of the newest matching entry
retired  out  1  one-cycle pulse when an entry drains
perf_retired  out  32  retire count (optional feature)
perf_rf_stall  out  32  rf_busy stall cycles (optional feature)

Behaviour:
- Interface: clk and rst only; rst is synchronous and active-high.
- Entry fields: {wb_en, dest, value}. value = mem_r_en_in ? mem_data_in : alu_result_in, fixed at capture.
- FSM on occupancy: EMPTY(0), ONE(1), FULL(2). Registered state plus head pointer (1 bit).
- in_ready = !freeze && state != FULL. Depends only on registered state and freeze, never on in_valid.
- accept = in_valid && in_ready. Entry is written at the tail on the clock edge.
- drain = state != EMPTY && !freeze && (!head.wb_en || !rf_busy).
- On drain:
  - wb_en = head.wb_en. wb_dest and wb_value come from the head, combinationally in that cycle.
  - retired = 1. Head advances on the edge.
- Entries with wb_en=0 (stores, branches) drain regardless of rf_busy and produce no write.
- When not draining: wb_en=0, retired=0. wb_dest and wb_value show the head, or 0 if EMPTY.
- Latency: accepted at edge N → earliest write in cycle N+1 (one cycle).
- Transitions:
  - EMPTY: accept → ONE.
  - ONE: accept and drain → ONE; accept only → FULL; drain only → EMPTY.
  - FULL: drain → ONE; no accept possible.
- Throughput: 1 per cycle sustained while rf_busy=0.
- freeze: no accept, no drain; buffer contents held; perf counters not incremented.
- Forwarding: search the valid entries with wb_en=1 and dest==fwd_src. Newest (tail-side) match wins.
  - Incoming in_valid data is not searched.
  - An entry draining this cycle still hits.
  - No match: fwd_hit=0, fwd_value=0.
- Reset values: state=EMPTY, head=0, entries cleared to 0. All outputs 0, except in_ready=!freeze. Counters 0.
- Reset mid-operation discards buffered entries with no write; reset has priority over accept and drain.

Optional Feature:
- Macro: WB_PERF_CNT_EN.
- Defined:
  - perf_retired increments on every drain.
  - perf_rf_stall increments every cycle with state!=EMPTY, !freeze, head.wb_en=1 and rf_busy=1.
  - Both counters wrap at 2^32 and are cleared by rst.
- Undefined: both ports tied to 0, no counter flops.

Decomposition:
- Package wb_pkg holds:
  - wb_entry_t struct {wb_en, dest, value}
  - WB_DEPTH=2
  - the state enum {WB_EMPTY, WB_ONE, WB_FULL}
- Sub-module wb_skid_buf: 2-entry storage, pointers, FSM, and the forwarding search.
- wb_stage keeps the value mux, the drain/rf_busy logic and the perf counters.

Test Plan:
- Reset, then 3 back-to-back accepts (dest 1/2/3, alu 0x10/0x20/0x30, mem_r_en=0), rf_busy=0 → wb_en writes 1=0x10, 2=0x20, 3=0x30 in consecutive cycles, each one cycle after its accept; in_ready stays 1.
- Load (mem_r_en=1, alu=0x100, mem_data=0xDEADBEEF, dest=5) → write r5=0xDEADBEEF.
- rf_busy=1 for 4 cycles with 3 offered results → FULL after 2 accepts, in_ready=0, third held; on release, writes in order; perf_rf_stall=4 with WB_PERF_CNT_EN.
- Buffer r7=0x1 then r7=0x2 under rf_busy, fwd_src=7 → fwd_hit=1, fwd_value=0x2; fwd_src=8 → fwd_hit=0.
- Entry with wb_en=0 at head while rf_busy=1 → drains, retired=1, wb_en=0.
- FULL buffer, rst asserted one cycle → no writes, state EMPTY, in_ready=1, perf_retired=0.
